udp_ingress_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single byte-wide write port of `udp_top` (`wr_en`/`wr_sof`/`wr_eof`/`data_din`/`full`) among `NUM_PORTS` packet sources. A grant is locked from SOF to EOF so packets are never interleaved. Bytes that arrive outside a packet are discarded and counted. The block sits directly in front of `udp_top`, replacing the bench/MAC direct connection.

---
 rtl/udp_arb_pkg.sv | 27 ++
 rtl/udp_rr_picker.sv | 37 +++
 rtl/udp_ingress_arb.sv | 192 +++++++++++++++++++
 tb/tb_udp_ingress_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/udp_arb_pkg.sv
// udp_arb_pkg: shared types and constants for the UDP ingress arbiter slice.
//   arb_state_t : arbiter FSM encoding (IDLE, BUSY)
//   BYTE_W      : width of one data byte lane
//   MAX_PORTS   : largest supported requester count
//   IDX_W       : width of a port index covering MAX_PORTS
//   count_ones  : population count of a MAX_PORTS-wide vector
package udp_arb_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MAX_PORTS = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [3:0] count_ones(input logic [MAX_PORTS-1:0] vec);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            n = n + 4'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/udp_rr_picker.sv
// udp_rr_picker: combinational round-robin selector.
// Searches req starting at last+1, wrapping modulo NUM_PORTS.
//   req      in  NUM_PORTS  request vector
//   last     in  IDX_W      index of the previous winner
//   gnt      out NUM_PORTS  one-hot winner (zero when no request)
//   gnt_idx  out IDX_W      index of the winner
//   gnt_any  out 1          at least one request present
module udp_rr_picker
    import udp_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_any
);

    always_comb begin
        logic found;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            int unsigned p;
            p = (32'(last) + i) % NUM_PORTS;
            if (!found && req[p]) begin
                found   = 1'b1;
                gnt[p]  = 1'b1;
                gnt_idx = IDX_W'(p);
            end
        end
        gnt_any = found;
    end

endmodule

// File: rtl/udp_ingress_arb.sv
// udp_ingress_arb: packet-granular round-robin arbiter in front of udp_top.
// A grant is held from SOF to EOF; bytes arriving outside a packet are
// accepted, discarded and counted in drop_count.
// Optional build macro: UDP_ARB_STATS_EN adds per-port forwarded-packet counters.
//   clock       in  1                    system clock
//   reset       in  1                    asynchronous, active-low reset
//   req_valid   in  NUM_PORTS            per-port byte valid
//   req_sof     in  NUM_PORTS            per-port first byte of packet
//   req_eof     in  NUM_PORTS            per-port last byte of packet
//   req_data    in  NUM_PORTS*8          port p at [8p+7:8p]
//   req_ready   out NUM_PORTS            byte consumed (forwarded or dropped)
//   wr_en       out 1                    write strobe to udp_top
//   wr_sof      out 1                    SOF to udp_top
//   wr_eof      out 1                    EOF to udp_top
//   data_din    out 8                    byte to udp_top
//   full        in  1                    udp_top input FIFO full
//   grant       out NUM_PORTS            one-hot owner, zero when idle
//   busy        out 1                    packet in progress
//   drop_count  out CNT_WIDTH            saturating discarded-byte count
//   pkt_count   out NUM_PORTS*CNT_WIDTH  (UDP_ARB_STATS_EN) per-port EOF count
module udp_ingress_arb
    import udp_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_sof,
    input  logic [NUM_PORTS-1:0]          req_eof,
    input  logic [NUM_PORTS*BYTE_W-1:0]   req_data,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic                          wr_en,
    output logic                          wr_sof,
    output logic                          wr_eof,
    output logic [BYTE_W-1:0]             data_din,
    input  logic                          full,
    output logic [NUM_PORTS-1:0]          grant,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          drop_count
`ifdef UDP_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_count
`endif
);

    arb_state_t             state, state_next;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic [CNT_WIDTH-1:0]   drop_count_q;

    logic [NUM_PORTS-1:0]   cand;
    logic [NUM_PORTS-1:0]   pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    logic                   own_valid;
    logic                   own_sof;
    logic                   own_eof;
    logic [BYTE_W-1:0]      own_data;
    logic                   xfer;
    logic                   xfer_eof;
    logic [NUM_PORTS-1:0]   drop_vec;

    assign cand = req_valid & req_sof;

    udp_rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req     (cand),
        .last    (last_grant_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Owner's lane selected by the one-hot grant (AND-OR mux).
    always_comb begin
        own_valid = 1'b0;
        own_sof   = 1'b0;
        own_eof   = 1'b0;
        own_data  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_q[p]) begin
                own_valid = own_valid | req_valid[p];
                own_sof   = own_sof   | req_sof[p];
                own_eof   = own_eof   | req_eof[p];
                own_data  = own_data  | req_data[p*BYTE_W +: BYTE_W];
            end
        end
    end

    assign xfer     = (state == BUSY) && own_valid && !full;
    assign xfer_eof = xfer && own_eof;
    assign drop_vec = (state == IDLE) ? (req_valid & ~req_sof) : '0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (pick_any) state_next = BUSY;
            BUSY: if (xfer_eof) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Gated by reset so every output reads 0 while reset is held, including
    // the IDLE drop handshake that would otherwise follow the inputs.
    always_comb begin
        req_ready = '0;
        wr_en     = 1'b0;
        wr_sof    = 1'b0;
        wr_eof    = 1'b0;
        data_din  = '0;
        if (reset) begin
            unique case (state)
                IDLE: req_ready = req_valid & ~req_sof;
                BUSY: begin
                    req_ready = grant_q & {NUM_PORTS{~full}};
                    wr_en     = xfer;
                    wr_sof    = xfer & own_sof;
                    wr_eof    = xfer & own_eof;
                    data_din  = own_data;
                end
                default: ;
            endcase
        end
    end

    // ---------------- grant bookkeeping ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else if (state == IDLE && pick_any) begin
            grant_q <= pick_gnt;
            owner_q <= pick_idx;
        end else if (xfer_eof) begin
            grant_q      <= '0;
            last_grant_q <= owner_q;
        end
    end

    // ---------------- drop counter ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_count_q <= '0;
        end else begin
            logic [CNT_WIDTH+3:0] sum;
            sum = (CNT_WIDTH+4)'(drop_count_q)
                + (CNT_WIDTH+4)'(count_ones(MAX_PORTS'(drop_vec)));
            if (|sum[CNT_WIDTH+3:CNT_WIDTH]) begin
                drop_count_q <= '1;
            end else begin
                drop_count_q <= sum[CNT_WIDTH-1:0];
            end
        end
    end

`ifdef UDP_ARB_STATS_EN
    // ---------------- per-port forwarded-packet counters ----------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pkt_cnt
        logic [CNT_WIDTH-1:0] cnt_q;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else if (xfer_eof && grant_q[p] && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign pkt_count[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`endif

    assign grant      = grant_q;
    assign busy       = (state == BUSY);
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_udp_ingress_arb.sv
// tb_udp_ingress_arb: directed self-checking bench for udp_ingress_arb
// with two ports. Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 unit later, well away from the next edge.
module tb_udp_ingress_arb;

    localparam int unsigned NP = 2;
    localparam int unsigned CW = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_sof   = '0;
    logic [NP-1:0]     req_eof   = '0;
    logic [NP*8-1:0]   req_data  = '0;
    logic [NP-1:0]     req_ready;
    logic              wr_en;
    logic              wr_sof;
    logic              wr_eof;
    logic [7:0]        data_din;
    logic              full = 1'b0;
    logic [NP-1:0]     grant;
    logic              busy;
    logic [CW-1:0]     drop_count;
`ifdef UDP_ARB_STATS_EN
    logic [NP*CW-1:0]  pkt_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    udp_ingress_arb #(
        .NUM_PORTS (NP),
        .CNT_WIDTH (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_sof    (req_sof),
        .req_eof    (req_eof),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr_en      (wr_en),
        .wr_sof     (wr_sof),
        .wr_eof     (wr_eof),
        .data_din   (data_din),
        .full       (full),
        .grant      (grant),
        .busy       (busy),
        .drop_count (drop_count)
`ifdef UDP_ARB_STATS_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic s, input logic e,
                         input logic [7:0] d);
        req_valid[p]        = v;
        req_sof[p]          = s;
        req_eof[p]          = e;
        req_data[p*8 +: 8]  = d;
    endtask

    // Decision cycle, then len transfers from port p with bytes base, base+1, ...
    // If abort_at >= 0, reset is asserted while byte abort_at is presented.
    task automatic run_pkt(input int p, input int len, input logic [7:0] base,
                           input int abort_at);
        logic [NP-1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        drive(p, 1'b1, 1'b1, (len == 1), base);
        #1;
        chk("dec_wr_en", wr_en, 0);
        chk("dec_ready", req_ready, 0);
        chk("dec_busy", busy, 0);
        tick();
        chk("grant", grant, oh);
        for (int i = 0; i < len; i++) begin
            drive(p, 1'b1, (i == 0), (i == len - 1), base + 8'(i));
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                chk("rst_wr_en", wr_en, 0);
                chk("rst_wr_sof", wr_sof, 0);
                chk("rst_data", data_din, 0);
                chk("rst_ready", req_ready, 0);
                chk("rst_grant", grant, 0);
                chk("rst_busy", busy, 0);
                chk("rst_drop", drop_count, 0);
`ifdef UDP_ARB_STATS_EN
                chk("rst_pkt0", pkt_count[CW-1:0], 0);
`endif
                drive(p, 1'b0, 1'b0, 1'b0, 8'h00);
                #1;
                reset = 1'b1;
                tick();
                return;
            end
            #1;
            chk("xf_wr_en", wr_en, 1);
            chk("xf_wr_sof", wr_sof, (i == 0));
            chk("xf_wr_eof", wr_eof, (i == len - 1));
            chk("xf_data", data_din, base + 8'(i));
            chk("xf_ready", req_ready, oh);
            chk("xf_busy", busy, 1);
            chk("xf_grant", grant, oh);
            tick();
        end
        drive(p, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("end_busy", busy, 0);
        chk("end_grant", grant, 0);
        chk("end_wr_en", wr_en, 0);
    endtask

    initial begin
        int bi;

        // ---- reset state; port 1 drives a stray byte that must not be acked
        drive(1, 1'b1, 1'b0, 1'b0, 8'h33);
        #12;
        chk("reset_ready", req_ready, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_data", data_din, 0);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_drop", drop_count, 0);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        reset = 1'b1;
        tick();

        // ---- 3 non-SOF bytes on port 1 in IDLE are dropped
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 8'h11 + 8'(i));
            #1;
            chk("drop_ready", req_ready, 2'b10);
            chk("drop_wr_en", wr_en, 0);
            chk("drop_busy", busy, 0);
            chk("drop_cnt_run", drop_count, i);
            tick();
        end
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("drop_cnt", drop_count, 3);
        chk("drop_grant", grant, 0);

        // ---- port 0 alone, 60 bytes
        run_pkt(0, 60, 8'h10, -1);

        // ---- port 1, 8 bytes, full high for 5 cycles starting at byte 3
        drive(1, 1'b1, 1'b1, 1'b0, 8'hC0);
        #1;
        chk("st_dec_wr_en", wr_en, 0);
        tick();
        chk("st_grant", grant, 2'b10);
        bi = 0;
        for (int c = 0; c < 13; c++) begin
            full = (c >= 3 && c < 8);
            drive(1, 1'b1, (bi == 0), (bi == 7), 8'hC0 + 8'(bi));
            #1;
            if (full) begin
                chk("st_wr_en", wr_en, 0);
                chk("st_ready", req_ready, 0);
                chk("st_grant_hold", grant, 2'b10);
                chk("st_busy", busy, 1);
            end else begin
                chk("st_xf_wr_en", wr_en, 1);
                chk("st_xf_data", data_din, 8'hC0 + 8'(bi));
                chk("st_xf_eof", wr_eof, (bi == 7));
                chk("st_xf_ready", req_ready, 2'b10);
            end
            tick();
            if (!full) bi++;
        end
        full = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("st_end_busy", busy, 0);
        chk("st_bytes", bi, 8);

        // ---- reset at byte 20 of a 40-byte packet on port 0
        run_pkt(0, 40, 8'h00, 20);

        // ---- simultaneous SOF after reset: port 0 first, then port 1
        drive(1, 1'b1, 1'b1, 1'b0, 8'h80);
        run_pkt(0, 10, 8'h40, -1);
        run_pkt(1, 10, 8'h80, -1);

        // ---- single-byte packet on port 0
        run_pkt(0, 1, 8'hA5, -1);

        // ---- pair again: last winner was port 0, so port 1 goes first
        drive(0, 1'b1, 1'b1, 1'b0, 8'h50);
        run_pkt(1, 10, 8'h90, -1);
        run_pkt(0, 10, 8'h50, -1);

        chk("final_drop", drop_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
